// File: rtl/nvdla_dbb_responder.sv
// nvdla_dbb_responder: memory-side responder for the NVDLA DBB interface.
// Splits DBB read/write bursts into single-beat req/gnt/rvalid memory accesses.
// One burst is in flight at a time. Read data returns through a 2-entry FIFO
// that keeps draining while the next burst starts.
// Optional protocol checker: define NVDLA_DBB_RESP_CHECK_EN to build the sticky
// err_o logic. When it is undefined, err_o is tied to 0.
module nvdla_dbb_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_req_valid_i,
  output logic                    wr_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr_i,
  input  logic [LEN_WIDTH-1:0]    wr_req_len_i,
  input  logic [ID_WIDTH-1:0]     wr_req_id_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr_i,
  input  logic [LEN_WIDTH-1:0]    rd_req_len_i,
  input  logic [ID_WIDTH-1:0]     rd_req_id_i,
  input  logic                    wdat_valid_i,
  output logic                    wdat_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdat_data_i,
  input  logic [DATA_WIDTH/8-1:0] wdat_strb_i,
  input  logic                    wdat_last_i,
  output logic                    wrsp_valid_o,
  input  logic                    wrsp_ready_i,
  output logic [ID_WIDTH-1:0]     wrsp_id_o,
  output logic                    rdat_valid_o,
  input  logic                    rdat_ready_i,
  output logic [DATA_WIDTH-1:0]   rdat_data_o,
  output logic                    rdat_last_o,
  output logic [ID_WIDTH-1:0]     rdat_id_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [ID_WIDTH-1:0]   id;
  logic [LEN_WIDTH:0]    beat_cnt;   // write beats granted / read beats issued
  logic [LEN_WIDTH-1:0]  ret_cnt;    // read beats returned from memory
  logic                  outstanding;
  logic                  last_wr;    // last served burst was a write

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic [ID_WIDTH-1:0]   fifo_id [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_count;

  logic       sel_wr;
  logic       wr_hs;
  logic       rd_hs;
  logic       wr_beat;
  logic       rd_issue;
  logic       rd_gnt;
  logic       push;
  logic       pop;
  logic [2:0] occ;

  // Request arbitration: only the round-robin winner sees ready in IDLE
  always_comb begin
    sel_wr         = wr_req_valid_i && (!rd_req_valid_i || !last_wr);
    wr_req_ready_o = (state == IDLE) && sel_wr;
    rd_req_ready_o = (state == IDLE) && rd_req_valid_i && !sel_wr;
    wr_hs          = wr_req_valid_i && wr_req_ready_o;
    rd_hs          = rd_req_valid_i && rd_req_ready_o;
  end

  // Read issue gating. A pop this cycle frees a slot before the data of a read
  // granted now can arrive, so counting it keeps 1 beat/cycle throughput while
  // never exceeding the two FIFO entries.
  always_comb begin
    pop      = rdat_valid_o && rdat_ready_i;
    push     = outstanding && mem_rvalid_i;
    occ      = 3'(fifo_count) + 3'(outstanding) - 3'(pop);
    rd_issue = (state == READ) && (beat_cnt <= {1'b0, len}) && (occ < 3'd2);
    rd_gnt   = rd_issue && mem_gnt_i;
    wr_beat  = (state == WRITE) && wdat_valid_i && mem_gnt_i;
  end

  // Memory port and write-data channel decode
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_wdata_o  = '0;
    mem_addr_o   = '0;
    wdat_ready_o = 1'b0;
    unique case (state)
      WRITE: begin
        mem_req_o    = wdat_valid_i;
        mem_we_o     = 1'b1;
        mem_be_o     = wdat_strb_i;
        mem_wdata_o  = wdat_data_i;
        mem_addr_o   = addr;
        wdat_ready_o = mem_gnt_i;
      end
      READ: begin
        mem_req_o  = rd_issue;
        mem_be_o   = '1;
        mem_addr_o = addr;
      end
      default: ;
    endcase
  end

  // Response channels and status
  always_comb begin
    wrsp_valid_o = (state == WRITE_RESP);
    wrsp_id_o    = (state == WRITE_RESP) ? id : '0;
    rdat_valid_o = (fifo_count != 2'd0);
    rdat_data_o  = fifo_data[rd_ptr];
    rdat_last_o  = fifo_last[rd_ptr];
    rdat_id_o    = fifo_id[rd_ptr];
    busy_o       = (state != IDLE) || (fifo_count != 2'd0);
  end

  // Burst sequencing FSM with address/beat bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      addr        <= '0;
      len         <= '0;
      id          <= '0;
      beat_cnt    <= '0;
      ret_cnt     <= '0;
      outstanding <= 1'b0;
      last_wr     <= 1'b0;
    end else begin
      if (rd_gnt) begin
        outstanding <= 1'b1;
      end else if (mem_rvalid_i) begin
        outstanding <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (wr_hs) begin
            addr     <= wr_req_addr_i;
            len      <= wr_req_len_i;
            id       <= wr_req_id_i;
            beat_cnt <= '0;
            last_wr  <= 1'b1;
            state    <= WRITE;
          end else if (rd_hs) begin
            addr     <= rd_req_addr_i;
            len      <= rd_req_len_i;
            id       <= rd_req_id_i;
            beat_cnt <= '0;
            ret_cnt  <= '0;
            last_wr  <= 1'b0;
            state    <= READ;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            addr     <= addr + BEAT_BYTES;
            beat_cnt <= beat_cnt + (LEN_WIDTH+1)'(1);
            if (beat_cnt[LEN_WIDTH-1:0] == len) begin
              state <= WRITE_RESP;
            end
          end
        end
        WRITE_RESP: begin
          if (wrsp_ready_i) begin
            state <= IDLE;
          end
        end
        READ: begin
          if (rd_gnt) begin
            addr     <= addr + BEAT_BYTES;
            beat_cnt <= beat_cnt + (LEN_WIDTH+1)'(1);
          end
          if (push) begin
            ret_cnt <= ret_cnt + LEN_WIDTH'(1);
            if (ret_cnt == len) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read return FIFO (2 entries, simultaneous push/pop allowed when full)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_id[i]   <= '0;
      end
      fifo_last  <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata_i;
        fifo_last[wr_ptr] <= (ret_cnt == len);
        fifo_id[wr_ptr]   <= id;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + 2'(push) - 2'(pop);
    end
  end

`ifdef NVDLA_DBB_RESP_CHECK_EN
  logic err;

  // Sticky protocol checker: mismatched last marker or write data outside a burst
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if ((wr_beat && (wdat_last_i != (beat_cnt[LEN_WIDTH-1:0] == len))) ||
                 (((state == IDLE) || (state == WRITE_RESP)) && wdat_valid_i)) begin
      err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  logic unused_last;
  assign unused_last = wdat_last_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_nvdla_dbb_responder.sv
// Testbench for nvdla_dbb_responder: table-driven bursts, hand-written corner
// sequences and a randomized phase, all scored against a queue/array model.
module tb_nvdla_dbb_responder;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        wr_req_valid_i, wr_req_ready_o;
  logic [31:0] wr_req_addr_i;
  logic [3:0]  wr_req_len_i;
  logic [7:0]  wr_req_id_i;
  logic        rd_req_valid_i, rd_req_ready_o;
  logic [31:0] rd_req_addr_i;
  logic [3:0]  rd_req_len_i;
  logic [7:0]  rd_req_id_i;
  logic        wdat_valid_i, wdat_ready_o, wdat_last_i;
  logic [63:0] wdat_data_i;
  logic [7:0]  wdat_strb_i;
  logic        wrsp_valid_o, wrsp_ready_i;
  logic [7:0]  wrsp_id_o;
  logic        rdat_valid_o, rdat_ready_i, rdat_last_o;
  logic [63:0] rdat_data_o;
  logic [7:0]  rdat_id_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_wdata_o, mem_rdata_i;
  logic        busy_o, err_o;

  always #5 clk = ~clk;

  nvdla_dbb_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(8), .LEN_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i), .wr_req_id_i(wr_req_id_i),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i), .rd_req_id_i(rd_req_id_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_data_i(wdat_data_i),
    .wdat_strb_i(wdat_strb_i), .wdat_last_i(wdat_last_i),
    .wrsp_valid_o(wrsp_valid_o), .wrsp_ready_i(wrsp_ready_i), .wrsp_id_o(wrsp_id_o),
    .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i), .rdat_data_o(rdat_data_o),
    .rdat_last_o(rdat_last_o), .rdat_id_o(rdat_id_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

`ifdef NVDLA_DBB_RESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    bit          last;
    logic [7:0]  id;
  } rbeat_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  id;
    logic [31:0] last_addr;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [63:0] model_mem [logic [31:0]];
  logic [63:0] phys_mem  [logic [31:0]];
  rbeat_t      rexp[$];
  logic [31:0] raddr_exp[$];
  logic [7:0]  wrsp_exp[$];
  bit          served[$];
  bit          exp_err = 1'b0;

  // stimulus state
  bit          dense = 1'b1;
  int          stall_rdy = 0;
  bit          wr_pend = 1'b0, rd_pend = 1'b0;
  logic [31:0] wr_a, rd_a;
  logic [3:0]  wr_l, rd_l;
  logic [7:0]  wr_i, rd_i;
  int          wleft = 0, widx = 0, bad_beat = -1;
  logic [3:0]  wlen_act;
  logic [31:0] waddr_nxt;
  logic [63:0] wd;
  logic [7:0]  ws;
  bit          pend_rd = 1'b0, force_rv = 1'b0;
  logic [31:0] pend_addr;
  logic [31:0] last_maddr;
  int          mcount = 0, issued_rd = 0, popped_rd = 0;
  bit          prev_rstall = 1'b0, prev_wstall = 1'b0;
  rbeat_t      prev_r;
  logic [7:0]  prev_wid;

  function automatic logic [63:0] initval(logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic logic [63:0] model_rd(logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : initval(a);
  endfunction

  function automatic logic [63:0] phys_rd(logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : initval(a);
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] be);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic new_wbeat();
    wd = {$urandom, $urandom};
    ws = 8'($urandom_range(0, 255));
  endtask

  task automatic load_wr(input logic [31:0] a, input logic [3:0] l, input logic [7:0] i);
    wr_pend = 1'b1; wr_a = a; wr_l = l; wr_i = i;
  endtask

  task automatic load_rd(input logic [31:0] a, input logic [3:0] l, input logic [7:0] i);
    rd_pend = 1'b1; rd_a = a; rd_l = l; rd_i = i;
  endtask

  // One clock cycle: drive at the falling edge, score 1 time unit later,
  // then wait for the next falling edge (the rising edge happens in between).
  task automatic step();
    bit     wr_hs, rd_hs, wb_hs, newpend;
    rbeat_t e;
    wr_req_valid_i = wr_pend; wr_req_addr_i = wr_a; wr_req_len_i = wr_l; wr_req_id_i = wr_i;
    rd_req_valid_i = rd_pend; rd_req_addr_i = rd_a; rd_req_len_i = rd_l; rd_req_id_i = rd_i;
    wdat_valid_i = (wleft > 0) && (dense || ($urandom_range(0, 3) != 0));
    wdat_data_i  = wd;
    wdat_strb_i  = ws;
    wdat_last_i  = (widx == int'(wlen_act)) ^ (widx == bad_beat);
    mem_gnt_i    = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
    rdat_ready_i = (stall_rdy > 0) ? 1'b0 : (dense ? 1'b1 : ($urandom_range(0, 3) != 0));
    wrsp_ready_i = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
    mem_rvalid_i = pend_rd || force_rv;
    mem_rdata_i  = pend_rd ? phys_rd(pend_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    force_rv     = 1'b0;
    #1;
    newpend = 1'b0;
    if (rst_ni) begin
      chk("err_o", err_o, exp_err);
      chk("single ready", wr_req_ready_o && rd_req_ready_o, 1'b0);
      if (prev_rstall)
        chk("rdat stable", {rdat_valid_o, rdat_data_o, rdat_last_o, rdat_id_o},
            {1'b1, prev_r.data, prev_r.last, prev_r.id});
      if (prev_wstall)
        chk("wrsp stable", {wrsp_valid_o, wrsp_id_o}, {1'b1, prev_wid});
      wb_hs = wdat_valid_i && wdat_ready_o;
      if (wb_hs) begin
        chk("mem write", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
            {2'b11, waddr_nxt, wd, ws});
        phys_mem[mem_addr_o] = merge(phys_rd(mem_addr_o), mem_wdata_o, mem_be_o);
        model_mem[waddr_nxt] = merge(model_rd(waddr_nxt), wd, ws);
        if (ERR_EN && (wdat_last_i != (widx == int'(wlen_act)))) exp_err = 1'b1;
      end else if (mem_req_o && mem_gnt_i && mem_we_o) begin
        note_fail("unexpected mem write");
      end
      if (mem_req_o && mem_gnt_i) begin
        mcount++;
        last_maddr = mem_addr_o;
      end
      if (mem_req_o && mem_gnt_i && !mem_we_o) begin
        if (raddr_exp.size() == 0) note_fail("unexpected mem read");
        else chk("mem read", {mem_addr_o, mem_be_o}, {raddr_exp.pop_front(), 8'hFF});
        issued_rd++;
        newpend   = 1'b1;
        pend_addr = mem_addr_o;
      end
      if (rdat_valid_o && rdat_ready_i) begin
        if (rexp.size() == 0) note_fail("unexpected rdat");
        else begin
          e = rexp.pop_front();
          chk("rdat", {rdat_data_o, rdat_last_o, rdat_id_o}, {e.data, e.last, e.id});
        end
        popped_rd++;
      end
      if (wrsp_valid_o && wrsp_ready_i) begin
        if (wrsp_exp.size() == 0) note_fail("unexpected wrsp");
        else chk("wrsp id", wrsp_id_o, wrsp_exp.pop_front());
      end
      chk("read buffering", (issued_rd - popped_rd) <= 2, 1'b1);
      wr_hs = wr_req_valid_i && wr_req_ready_o;
      rd_hs = rd_req_valid_i && rd_req_ready_o;
      if (wb_hs) begin
        widx++;
        wleft--;
        waddr_nxt = waddr_nxt + 32'd8;
        new_wbeat();
      end
      if (wr_hs) begin
        wr_pend = 1'b0; wleft = int'(wr_l) + 1; widx = 0; wlen_act = wr_l; waddr_nxt = wr_a;
        new_wbeat();
        wrsp_exp.push_back(wr_i);
        served.push_back(1'b1);
      end
      if (rd_hs) begin
        rd_pend = 1'b0;
        for (int i = 0; i <= int'(rd_l); i++) begin
          logic [31:0] a = rd_a + 32'(i * 8);
          raddr_exp.push_back(a);
          rexp.push_back('{data: model_rd(a), last: (i == int'(rd_l)), id: rd_i});
        end
        served.push_back(1'b0);
      end
      prev_rstall = rdat_valid_o && !rdat_ready_i;
      prev_r      = '{data: rdat_data_o, last: rdat_last_o, id: rdat_id_o};
      prev_wstall = wrsp_valid_o && !wrsp_ready_i;
      prev_wid    = wrsp_id_o;
    end else begin
      prev_rstall = 1'b0;
      prev_wstall = 1'b0;
    end
    pend_rd = newpend;
    if (stall_rdy > 0) stall_rdy--;
    @(negedge clk);
  endtask

  task automatic run_idle(input int max);
    int k = 0;
    while (!(!wr_pend && !rd_pend && wleft == 0 && rexp.size() == 0 &&
             wrsp_exp.size() == 0 && !busy_o) && k < max) begin
      step();
      k++;
    end
    if (k >= max) note_fail("run_idle");
    else chk("all reads issued", raddr_exp.size(), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " ctrl"}, {wr_req_ready_o, rd_req_ready_o, wdat_ready_o, wrsp_valid_o,
        rdat_valid_o, rdat_last_o, mem_req_o, mem_we_o, busy_o, err_o}, 10'd0);
    chk({name, " data"}, {rdat_data_o, mem_wdata_o}, 128'd0);
    chk({name, " addr/id/be"}, {mem_addr_o, mem_be_o, wrsp_id_o, rdat_id_o}, 56'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [6:0] order;
    int base, guard;
    vecs[0] = '{1'b1, 32'h0000_0100, 4'd3,  8'h5A, 32'h0000_0118};
    vecs[1] = '{1'b0, 32'h0000_0200, 4'd1,  8'h11, 32'h0000_0208};
    vecs[2] = '{1'b1, 32'hFFFF_FFF8, 4'd1,  8'h21, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'hFFFF_FFF8, 4'd1,  8'h22, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0300, 4'd0,  8'h33, 32'h0000_0300};
    vecs[5] = '{1'b1, 32'h0000_1000, 4'd15, 8'h44, 32'h0000_1078};
    vecs[6] = '{1'b0, 32'h0000_1000, 4'd15, 8'h45, 32'h0000_1078};
    vecs[7] = '{1'b0, 32'h0000_0100, 4'd3,  8'h46, 32'h0000_0118};

    rst_ni = 1'b0;
    wr_req_valid_i = 0; wr_req_addr_i = 0; wr_req_len_i = 0; wr_req_id_i = 0;
    rd_req_valid_i = 0; rd_req_addr_i = 0; rd_req_len_i = 0; rd_req_id_i = 0;
    wdat_valid_i = 0; wdat_data_i = 0; wdat_strb_i = 0; wdat_last_i = 0;
    wrsp_ready_i = 0; rdat_ready_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    wr_a = 0; wr_l = 0; wr_i = 0; rd_a = 0; rd_l = 0; rd_i = 0; wlen_act = 0;
    waddr_nxt = 0; pend_addr = 0; last_maddr = 0; wd = 0; ws = 0; prev_wid = 0;
    prev_r = '{data: 64'd0, last: 1'b0, id: 8'd0};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_ni = 1'b1;

    // table-driven single bursts
    for (int v = 0; v < 8; v++) begin
      dense  = 1'b1;
      mcount = 0;
      if (vecs[v].wr) load_wr(vecs[v].addr, vecs[v].len, vecs[v].id);
      else            load_rd(vecs[v].addr, vecs[v].len, vecs[v].id);
      run_idle(200);
      chk($sformatf("vec%0d last addr", v), last_maddr, vecs[v].last_addr);
      chk($sformatf("vec%0d beats", v), mcount, int'(vecs[v].len) + 1);
    end

    // read back-pressure: buffer fills to two, memory requests stop
    load_rd(32'h0000_4000, 4'd7, 8'h70);
    guard = 0;
    while (rd_pend && guard < 50) begin step(); guard++; end
    if (rd_pend) note_fail("stall accept");
    stall_rdy = 6;
    repeat (4) step();
    chk("stall mem_req low", mem_req_o, 1'b0);
    chk("stall rdat_valid", rdat_valid_o, 1'b1);
    chk("stall buffered", issued_rd - popped_rd, 2);
    run_idle(200);

    // wrong last marker on beat 1
    bad_beat = 1;
    load_wr(32'h0000_6000, 4'd3, 8'h66);
    run_idle(200);
    bad_beat = -1;
    repeat (3) step();
    chk("err sticky", err_o, ERR_EN);

    // reset in the middle of a read burst
    base = issued_rd;
    load_rd(32'h0000_5000, 4'd7, 8'h55);
    guard = 0;
    while ((issued_rd - base) < 2 && guard < 50) begin step(); guard++; end
    if ((issued_rd - base) < 2) note_fail("mid-read issue");
    rst_ni  = 1'b0;
    rd_pend = 1'b0;
    wr_pend = 1'b0;
    step();
    chk_zero("mid-read reset");
    rexp.delete(); raddr_exp.delete(); wrsp_exp.delete();
    wleft = 0; exp_err = 1'b0; issued_rd = 0; popped_rd = 0;
    rst_ni   = 1'b1;
    force_rv = 1'b1;
    step();
    chk("stale rvalid dropped", {rdat_valid_o, busy_o}, 2'b00);

    // round-robin ordering
    served.delete();
    load_wr(32'h0000_7000, 4'd1, 8'hA1); load_rd(32'h0000_7000, 4'd1, 8'hB1); run_idle(200);
    load_wr(32'h0000_7010, 4'd2, 8'hA2); load_rd(32'h0000_7008, 4'd2, 8'hB2); run_idle(200);
    load_wr(32'h0000_7020, 4'd0, 8'hA3); run_idle(200);
    load_wr(32'h0000_7028, 4'd0, 8'hA4); load_rd(32'h0000_7020, 4'd1, 8'hB4); run_idle(200);
    chk("rr count", served.size(), 7);
    order = '0;
    for (int i = 0; i < 7 && i < served.size(); i++) order[6-i] = served[i];
    chk("rr order", order, 7'b1010101);

    // randomized traffic with random grants and back-pressure
    dense = 1'b0;
    for (int n = 0; n < 80; n++) begin
      int sel = $urandom_range(0, 2);
      guard = 0;
      while (((sel != 1) && wr_pend) || ((sel != 0) && rd_pend)) begin
        step();
        guard++;
        if (guard > 500) break;
      end
      if (guard > 500) note_fail("random slot");
      if (sel != 1)
        load_wr(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 3) * 8)
                                            : 32'h0000_8000 + 32'($urandom_range(0, 31) * 8),
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if (sel != 0)
        load_rd(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 3) * 8)
                                            : 32'h0000_8000 + 32'($urandom_range(0, 31) * 8),
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) step();
    end
    run_idle(5000);
    chk("final busy", busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
